rca_pipe: RTL and testbench

RCA_PIPE -- requirements
Module: rca_pipe

---
 rtl/tarm_adder_pkg.sv | 23 ++
 rtl/rca_segment.sv | 33 +++
 rtl/rca_pipe.sv | 126 ++++++++++++
 tb/tb_rca_pipe.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tarm_adder_pkg.sv
// Shared types and sizing helpers for the pipelined ripple-carry adder.
package tarm_adder_pkg;

   typedef enum logic {
      EXACT  = 1'b0,
      APPROX = 1'b1
   } approx_mode_e;

   function automatic int seg_width(input int width, input int stages);
      return width / stages;
   endfunction

   // Approximate LSBs that land inside segment s, clamped to that segment.
   function automatic int seg_approx_bits(input int abits, input int sw,
                                          input int s);
      int r;
      r = abits - s * sw;
      if (r < 0)  r = 0;
      if (r > sw) r = sw;
      return r;
   endfunction

endpackage

// File: rtl/rca_segment.sv
// One ripple-carry slice; its low SEG_APPROX_BITS become OR-approximated.
module rca_segment #(
   parameter int SEG_W           = 4,
   parameter int SEG_APPROX_BITS = 0
) (
   input  logic [SEG_W-1:0] a,
   input  logic [SEG_W-1:0] b,
   input  logic             cin,
   input  logic             approx_en,
   output logic [SEG_W-1:0] sum,
   output logic             cout
);

   logic c;

   // In the approximate region the carry is just the generate of the
   // current bit, so the last one becomes the carry into the exact part.
   always_comb begin
      sum = '0;
      c   = cin;
      for (int i = 0; i < SEG_W; i++) begin
         if (approx_en && i < SEG_APPROX_BITS) begin
            sum[i] = a[i] | b[i];
            c      = a[i] & b[i];
         end else begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
         end
      end
      cout = c;
   end

endmodule

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder: one segment per stage, valid/ready flow.
module rca_pipe
   import tarm_adder_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int STAGES      = 2,
   parameter int APPROX_BITS = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             approx_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int SW = seg_width(WIDTH, STAGES);

   if (WIDTH % STAGES != 0) begin : g_bad_split
      $error("rca_pipe: WIDTH must be a multiple of STAGES");
   end
   if (APPROX_BITS < 0 || APPROX_BITS > WIDTH) begin : g_bad_approx
      $error("rca_pipe: APPROX_BITS out of range 0..WIDTH");
   end

   logic en_q;

   // Keeps in_ready low until the first clock edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) en_q <= 1'b0;
      else        en_q <= 1'b1;
   end

   for (genvar s = 0; s < STAGES; s++) begin : g_stg
      localparam int IW  = WIDTH - s * SW;
      localparam int SAB = seg_approx_bits(APPROX_BITS, SW, s);

      logic [IW-1:0]       ua, ub;
      logic                uv, uc;
      approx_mode_e        um;
      logic [(s+1)*SW-1:0] sum_d, sum_q;
      logic [SW-1:0]       ssum;
      logic                scout, dn, ld;
      logic                v_q, c_q;

      if (s == 0) begin : g_src
         assign uv    = in_valid & en_q;
         assign ua    = a;
         assign ub    = b;
         assign uc    = cin;
         assign um    = approx_en ? APPROX : EXACT;
         assign sum_d = ssum;
      end else begin : g_src
         assign uv    = g_stg[s-1].v_q;
         assign ua    = g_stg[s-1].g_fwd.a_q;
         assign ub    = g_stg[s-1].g_fwd.b_q;
         assign uc    = g_stg[s-1].c_q;
         assign um    = g_stg[s-1].g_fwd.m_q;
         assign sum_d = {ssum, g_stg[s-1].sum_q};
      end

      if (s == STAGES - 1) begin : g_dn
         assign dn = out_ready;
      end else begin : g_dn
         assign dn = g_stg[s+1].ld;
      end

      assign ld = ~v_q | dn;

      rca_segment #(
         .SEG_W          (SW),
         .SEG_APPROX_BITS(SAB)
      ) u_seg (
         .a        (ua[SW-1:0]),
         .b        (ub[SW-1:0]),
         .cin      (uc),
         .approx_en(um == APPROX),
         .sum      (ssum),
         .cout     (scout)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q   <= 1'b0;
            c_q   <= 1'b0;
            sum_q <= '0;
         end else if (ld) begin
            v_q <= uv;
            if (uv) begin
               c_q   <= scout;
               sum_q <= sum_d;
            end
         end
      end

      // Operand bits still to be added travel with the partial sum.
      if (s < STAGES - 1) begin : g_fwd
         logic [IW-SW-1:0] a_q, b_q;
         approx_mode_e     m_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
               m_q <= EXACT;
            end else if (ld && uv) begin
               a_q <= ua[IW-1:SW];
               b_q <= ub[IW-1:SW];
               m_q <= um;
            end
         end
      end
   end

   assign in_ready  = en_q & g_stg[0].ld;
   assign out_valid = g_stg[STAGES-1].v_q;
   assign sum       = g_stg[STAGES-1].sum_q;
   assign cout      = g_stg[STAGES-1].c_q;

endmodule

// File: tb/tb_rca_pipe.sv
// Scoreboard bench for rca_pipe: 8-bit/2-stage and 32-bit/4-stage instances.
module tb_rca_pipe;

   typedef struct {
      logic [32:0] exp;
      int          stamp;
      int          lat;
   } item_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   logic        v8 = 0, r8, ci8 = 0, ap8 = 0, ov8, or8 = 1, co8;
   logic [7:0]  a8 = 0, b8 = 0, s8;
   logic        v32 = 0, r32, ci32 = 0, ap32 = 0, ov32, or32 = 1, co32;
   logic [31:0] a32 = 0, b32 = 0, s32;

   item_t q8[$];
   item_t q32[$];
   logic [32:0] last8 = '0;
   bit d8 = 0, d32 = 0;

   rca_pipe #(.WIDTH(8), .STAGES(2), .APPROX_BITS(4)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(v8), .in_ready(r8),
      .a(a8), .b(b8), .cin(ci8), .approx_en(ap8),
      .out_valid(ov8), .out_ready(or8),
      .sum(s8), .cout(co8)
   );

   rca_pipe #(.WIDTH(32), .STAGES(4), .APPROX_BITS(11)) u_dut32 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(v32), .in_ready(r32),
      .a(a32), .b(b32), .cin(ci32), .approx_en(ap32),
      .out_valid(ov32), .out_ready(or32),
      .sum(s32), .cout(co32)
   );

   task automatic chk(input string nm, input longint unsigned act,
                      input longint unsigned exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   task automatic failnote(input string nm);
      n_chk++;
      $display("FAIL %s: bound expired", nm);
   endtask

   // Reference: exact add, or OR-ed low bits with a generate carry above.
   function automatic logic [32:0] model(input longint unsigned a,
                                         input longint unsigned b,
                                         input logic c, input logic ap,
                                         input int w, input int ab);
      longint unsigned r, lm, cy;
      if (!ap || ab == 0) begin
         r = a + b + 64'(c);
      end else begin
         lm = (64'd1 << ab) - 64'd1;
         cy = ((a & b) >> (ab - 1)) & 64'd1;
         r  = (((a >> ab) + (b >> ab) + cy) << ab) | ((a | b) & lm);
      end
      r = r & ((64'd1 << (w + 1)) - 64'd1);
      return r[32:0];
   endfunction

   task automatic send8(input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic ap,
                        input logic [32:0] exp, input int lat);
      int n;
      n  = 0;
      a8 = a; b8 = b; ci8 = c; ap8 = ap; v8 = 1'b1;
      @(negedge clk);
      while (!r8 && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!r8) failnote("accept8");
      else begin
         q8.push_back('{exp, cyc + 1, lat});
         if (lat != 0) chk("nobubble8", n, 0);
      end
      @(posedge clk); #1;
      v8 = 1'b0;
   endtask

   task automatic send32(input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic ap,
                         input logic [32:0] exp, input int lat);
      int n;
      n   = 0;
      a32 = a; b32 = b; ci32 = c; ap32 = ap; v32 = 1'b1;
      @(negedge clk);
      while (!r32 && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!r32) failnote("accept32");
      else begin
         q32.push_back('{exp, cyc + 1, lat});
         if (lat != 0) chk("nobubble32", n, 0);
      end
      @(posedge clk); #1;
      v32 = 1'b0;
   endtask

   always @(negedge clk) begin : mon8
      item_t it;
      if (rst_n && ov8 && or8) begin
         if (q8.size() == 0) failnote("extra8");
         else begin
            it = q8.pop_front();
            chk("res8", {co8, s8}, it.exp);
            if (it.lat != 0) chk("lat8", cyc - it.stamp + 1, it.lat);
            last8 = it.exp;
         end
      end
   end

   always @(negedge clk) begin : mon32
      item_t it;
      if (rst_n && ov32 && or32) begin
         if (q32.size() == 0) failnote("extra32");
         else begin
            it = q32.pop_front();
            chk("res32", {co32, s32}, it.exp);
            if (it.lat != 0) chk("lat32", cyc - it.stamp + 1, it.lat);
         end
      end
   end

   task automatic drain();
      int n;
      n = 0;
      while ((q8.size() != 0 || q32.size() != 0) && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (q8.size() != 0 || q32.size() != 0) failnote("drain");
      @(posedge clk); #1;
   endtask

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      logic [7:0]  ra8, rb8;
      logic [31:0] ra32, rb32;
      logic        rc, rp;
      int          cnt;

      repeat (3) @(negedge clk);
      chk("rst_ov8", ov8, 0);
      chk("rst_rdy8", r8, 0);
      chk("rst_sum8", {co8, s8}, 0);
      chk("rst_ov32", ov32, 0);
      chk("rst_rdy32", r32, 0);
      rst_n = 1'b1;
      #1;
      chk("rel_rdy8", r8, 0);
      @(posedge clk); #1;
      chk("rise_rdy8", r8, 1);
      chk("rise_rdy32", r32, 1);

      send8(8'hFF, 8'h01, 1'b0, 1'b0, 33'h100, 2);
      send8(8'h0F, 8'h01, 1'b1, 1'b1, 33'h00F, 2);
      send8(8'h0F, 8'h01, 1'b1, 1'b0, 33'h011, 2);
      send8(8'h08, 8'h08, 1'b0, 1'b1, 33'h018, 2);
      send8(8'hF8, 8'h08, 1'b1, 1'b1, 33'h108, 2);
      send32(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 33'h1_0000_0000, 4);
      send32(32'h0000_07FF, 32'h401, 1'b1, 1'b1, 33'h0FFF, 4);
      send32(32'h0000_07FF, 32'h401, 1'b1, 1'b0, 33'h0C01, 4);
      drain();

      fork
         for (int k = 0; k < 6; k++) begin
            ra8 = 8'($urandom); rb8 = 8'($urandom);
            rc  = 1'($urandom); rp  = 1'($urandom);
            send8(ra8, rb8, rc, rp, model(ra8, rb8, rc, rp, 8, 4), 0);
         end
         for (int k = 1; k <= 14; k++) begin
            or8 = !(k >= 3 && k <= 5);
            @(negedge clk);
            if (k == 5) begin
               chk("held_rdy8", r8, 0);
               chk("held_ov8", ov8, 1);
            end
            @(posedge clk); #1;
         end
      join
      or8 = 1'b1;
      drain();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("idle_ov8", ov8, 0);
      chk("hold8", {co8, s8}, last8);
      @(posedge clk); #1;

      or8 = 1'b0;
      send8(8'h12, 8'h34, 1'b0, 1'b0, 33'h046, 0);
      send8(8'h56, 8'h78, 1'b1, 1'b0, 33'h0CF, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ov8", ov8, 0);
      chk("mid_rst_rdy8", r8, 0);
      chk("mid_rst_sum8", {co8, s8}, 0);
      q8.delete();
      or8 = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (ov8) cnt++;
      end
      chk("stale8", cnt, 0);
      @(posedge clk); #1;

      fork
         begin
            for (int i = 0; i < 10000; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk); #1;
               end
               ra32 = $urandom; rb32 = $urandom;
               rc   = 1'($urandom); rp = 1'($urandom);
               send32(ra32, rb32, rc, rp,
                      model(ra32, rb32, rc, rp, 32, 11), 0);
            end
            d32 = 1'b1;
         end
         begin
            while (!d32) begin
               or32 = ($urandom_range(0, 3) != 0);
               @(posedge clk); #1;
            end
            or32 = 1'b1;
         end
         begin : rnd8
            logic [7:0] xa, xb;
            logic       xc, xp;
            for (int i = 0; i < 400; i++) begin
               xa = 8'($urandom); xb = 8'($urandom);
               xc = 1'($urandom); xp = 1'($urandom);
               send8(xa, xb, xc, xp, model(xa, xb, xc, xp, 8, 4), 0);
            end
            d8 = 1'b1;
         end
         begin
            while (!d8) begin
               or8 = ($urandom_range(0, 2) != 0);
               @(posedge clk); #1;
            end
            or8 = 1'b1;
         end
      join
      drain();
      chk("q8_empty", q8.size(), 0);
      chk("q32_empty", q32.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
